// File: rtl/fft_ram_sequencer_if.sv
// RAM compute port and butterfly handshake between the FFT sequencer and its
// datapath neighbours.
interface fft_ram_sequencer_if #(
    parameter int LOG2N  = 10,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              ram_mode;
    logic              ram_rd_en;
    logic [ADDR_W-1:0] ram_rd_addr;
    logic [DATA_W-1:0] ram_rd_data;
    logic [ADDR_W-1:0] ram_wr_addr;
    logic [DATA_W-1:0] ram_wr_data;
    logic              bf_valid;
    logic              bf_ready;
    logic [DATA_W-1:0] bf_a;
    logic [DATA_W-1:0] bf_b;
    logic [LOG2N-2:0]  bf_tw_idx;
    logic              bf_res_valid;
    logic [DATA_W-1:0] bf_res_a;
    logic [DATA_W-1:0] bf_res_b;

    modport master (
        output ram_mode, ram_rd_en, ram_rd_addr, ram_wr_addr, ram_wr_data,
        output bf_valid, bf_a, bf_b, bf_tw_idx,
        input  ram_rd_data, bf_ready, bf_res_valid, bf_res_a, bf_res_b
    );

    modport slave (
        input  ram_mode, ram_rd_en, ram_rd_addr, ram_wr_addr, ram_wr_data,
        input  bf_valid, bf_a, bf_b, bf_tw_idx,
        output ram_rd_data, bf_ready, bf_res_valid, bf_res_a, bf_res_b
    );
endinterface

// File: rtl/fft_ram_sequencer.sv
// In-place radix-2 DIT pass sequencer for the FFT working RAM. Per butterfly:
// read A, read B, hand both to the butterfly unit, wait for results, write
// A then B back. The host owns the RAM whenever the sequencer is idle.
module fft_ram_sequencer #(
    parameter int LOG2N  = 10,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic abort,
    output logic busy,
    output logic done,
    output logic host_grant,
    fft_ram_sequencer_if.master bus
);
    localparam int SW = (LOG2N > 1) ? $clog2(LOG2N) : 1;
    localparam int KW = LOG2N - 1;
    localparam logic [KW-1:0] K_LAST = '1;
    localparam logic [SW-1:0] S_LAST = SW'(LOG2N - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_RD_A, S_RD_B, S_CAP_B, S_ISSUE, S_WAIT_RES, S_WR_A, S_WR_B, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [SW-1:0]     stage_q, stage_d;
    logic [KW-1:0]     k_q, k_d;
    logic [DATA_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
    logic [DATA_W-1:0] res_a_q, res_a_d, res_b_q, res_b_d;
    logic [ADDR_W-1:0] span, pos, grp, addr_a, addr_b;
    logic [KW-1:0]     tw_idx;

    // Butterfly pair addresses and twiddle index for the current (stage, k).
    always_comb begin
        span   = ADDR_W'(1) << stage_q;
        pos    = ADDR_W'(k_q) & (span - ADDR_W'(1));
        grp    = ADDR_W'(k_q) >> stage_q;
        // shift by stage then by one so stage+1 never needs an extra bit
        addr_a = ((grp << stage_q) << 1) | pos;
        addr_b = addr_a + span;
        tw_idx = KW'(pos << (S_LAST - stage_q));
    end

    // State, loop counters and operand/result holding registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            stage_q <= '0;
            k_q     <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            res_a_q <= '0;
            res_b_q <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            k_q     <= k_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            res_a_q <= res_a_d;
            res_b_q <= res_b_d;
        end
    end

    // Next-state and loop sequencing; abort overrides every transition.
    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        k_d     = k_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        res_a_d = res_a_q;
        res_b_d = res_b_q;
        case (state_q)
            S_IDLE: if (start) begin
                state_d = S_RD_A;
                stage_d = '0;
                k_d     = '0;
            end
            S_RD_A:  state_d = S_RD_B;
            S_RD_B: begin
                op_a_d  = bus.ram_rd_data;
                state_d = S_CAP_B;
            end
            S_CAP_B: begin
                op_b_d  = bus.ram_rd_data;
                state_d = S_ISSUE;
            end
            S_ISSUE: if (bus.bf_ready) state_d = S_WAIT_RES;
            S_WAIT_RES: if (bus.bf_res_valid) begin
                res_a_d = bus.bf_res_a;
                res_b_d = bus.bf_res_b;
                state_d = S_WR_A;
            end
            S_WR_A:  state_d = S_WR_B;
            S_WR_B: begin
                if (k_q != K_LAST) begin
                    k_d     = k_q + KW'(1);
                    state_d = S_RD_A;
                end else if (stage_q != S_LAST) begin
                    stage_d = stage_q + SW'(1);
                    k_d     = '0;
                    state_d = S_RD_A;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort) state_d = S_IDLE;
    end

    // Outputs decode straight from registered state so they move only on edges.
    always_comb begin
        busy            = (state_q != S_IDLE);
        done            = (state_q == S_DONE);
        bus.ram_mode    = (state_q == S_IDLE) || (state_q == S_DONE);
        host_grant      = bus.ram_mode;
        // the RAM writes whenever the strobe is low in compute mode
        bus.ram_rd_en   = !((state_q == S_WR_A) || (state_q == S_WR_B));
        bus.ram_rd_addr = '0;
        bus.ram_wr_addr = '0;
        bus.ram_wr_data = '0;
        case (state_q)
            S_RD_A: bus.ram_rd_addr = addr_a;
            S_RD_B: bus.ram_rd_addr = addr_b;
            S_WR_A: begin
                bus.ram_wr_addr = addr_a;
                bus.ram_wr_data = res_a_q;
            end
            S_WR_B: begin
                bus.ram_wr_addr = addr_b;
                bus.ram_wr_data = res_b_q;
            end
            default: ;
        endcase
        bus.bf_valid  = (state_q == S_ISSUE);
        bus.bf_a      = op_a_q;
        bus.bf_b      = op_b_q;
        bus.bf_tw_idx = tw_idx;
    end
endmodule
